// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine.
//   state_e : copy FSM states
//   ADDR_W  : memory address width (addresses wrap modulo 2^ADDR_W)
package mem_copy_pkg;

   localparam int unsigned ADDR_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      STREAM,
      DRAIN,
      FIN
   } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Control + memory-port bundle for mem_copy_engine.
//   Control : start, src, dst, len        (into engine)
//             busy, done                  (out of engine)
//   Memory  : rd_addr, wr_addr, wr_enable, wr_data (out of engine)
//             rd_data                     (into engine, 1-cycle read latency)
//   Fill    : fill, fill_value            (only when MEM_COPY_FILL_EN is defined)
// Modports: master = the engine, slave = control block / memory side.
interface mem_copy_engine_if #(
   parameter int unsigned width = 16,
   parameter int unsigned LEN_W = 16
);
   import mem_copy_pkg::*;

   logic              start;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_enable;
   logic [width-1:0]  wr_data;
   logic [width-1:0]  rd_data;
`ifdef MEM_COPY_FILL_EN
   logic              fill;
   logic [width-1:0]  fill_value;
`endif

   modport master (
      input  start, src, dst, len, rd_data,
`ifdef MEM_COPY_FILL_EN
      input  fill, fill_value,
`endif
      output busy, done, rd_addr, wr_addr, wr_enable, wr_data
   );

   modport slave (
      output start, src, dst, len, rd_data,
`ifdef MEM_COPY_FILL_EN
      output fill, fill_value,
`endif
      input  busy, done, rd_addr, wr_addr, wr_enable, wr_data
   );

endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: moves len words from src to dst in one read-always memory,
// streaming one word per cycle after a single prime cycle.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (aborts a transfer, no done pulse)
//   bus   : mem_copy_engine_if.master (control handshake + memory port)
// Optional: define MEM_COPY_FILL_EN to add fill/fill_value; with fill=1 the
// destination is written with fill_value using the same timing as a copy.
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int unsigned width = 16,
   parameter int unsigned LEN_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_copy_engine_if.master bus
);

   state_e            r_state, w_state_d;
   logic [ADDR_W-1:0] r_src, r_dst, r_rd_hold;
   logic [LEN_W-1:0]  r_len, r_k, w_k_d;
   logic              w_accept, w_advance;
   logic [width-1:0]  w_src_data, w_wr_data;
   logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
   logic              w_busy, w_done, w_wr_enable;

`ifdef MEM_COPY_FILL_EN
   logic              r_fill;
   logic [width-1:0]  r_fill_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill       <= 1'b0;
         r_fill_value <= '0;
      end else if (w_accept) begin
         r_fill       <= bus.fill;
         r_fill_value <= bus.fill_value;
      end
   end

   // Fill mode leaves the read address parked; the memory is read-always so
   // this is harmless.
   assign w_advance  = !r_fill;
   assign w_src_data = r_fill ? r_fill_value : bus.rd_data;
`else
   assign w_advance  = 1'b1;
   assign w_src_data = bus.rd_data;
`endif

   // Start is honoured in IDLE and in FIN, so transfers can run back-to-back.
   assign w_accept = bus.start && ((r_state == IDLE) || (r_state == FIN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_k       <= '0;
         r_rd_hold <= '0;
      end else begin
         r_state   <= w_state_d;
         r_k       <= w_k_d;
         r_rd_hold <= w_rd_addr;
         if (w_accept) begin
            r_src <= bus.src;
            r_dst <= bus.dst;
            r_len <= bus.len;
         end
      end
   end

   // rd_data answers the address presented last cycle, so in STREAM the word
   // read at src+k-1 is written to dst+k-1 while src+k is being fetched.
   always_comb begin
      w_state_d   = r_state;
      w_k_d       = r_k;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_wr_enable = 1'b0;
      w_rd_addr   = r_rd_hold;
      w_wr_addr   = '0;
      w_wr_data   = '0;

      unique case (r_state)
         IDLE: begin
         end
         PRIME: begin
            w_busy = 1'b1;
            if (w_advance) w_rd_addr = r_src;
            w_state_d = (r_len == LEN_W'(1)) ? DRAIN : STREAM;
         end
         STREAM: begin
            w_busy      = 1'b1;
            if (w_advance) w_rd_addr = r_src + ADDR_W'(r_k);
            w_wr_addr   = r_dst + ADDR_W'(r_k) - ADDR_W'(1);
            w_wr_enable = 1'b1;
            w_wr_data   = w_src_data;
            w_k_d       = r_k + LEN_W'(1);
            if (r_k == r_len - LEN_W'(1)) w_state_d = DRAIN;
         end
         DRAIN: begin
            w_busy      = 1'b1;
            w_wr_addr   = r_dst + ADDR_W'(r_len) - ADDR_W'(1);
            w_wr_enable = 1'b1;
            w_wr_data   = w_src_data;
            w_state_d   = FIN;
         end
         FIN: begin
            w_done    = 1'b1;
            w_state_d = IDLE;
         end
         default: w_state_d = IDLE;
      endcase

      if (w_accept) begin
         w_state_d = (bus.len == '0) ? FIN : PRIME;
         w_k_d     = LEN_W'(1);
      end
   end

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.rd_addr   = w_rd_addr;
   assign bus.wr_addr   = w_wr_addr;
   assign bus.wr_enable = w_wr_enable;
   assign bus.wr_data   = w_wr_data;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural
// 64K x 16 read-always memory (1-cycle read latency).
// Define MEM_COPY_FILL_EN to also exercise the fill feature.
module tb_mem_copy_engine;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_copy_engine_if #(.width(16), .LEN_W(16)) bus ();

   mem_copy_engine #(.width(16), .LEN_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory model; the bench preloads it through its own write port.
   logic [15:0] mem [0:65535];
   logic [15:0] rd_q;
   logic        tb_we;
   logic [15:0] tb_waddr, tb_wdata;

   always @(posedge clk) begin
      if (tb_we) mem[tb_waddr] <= tb_wdata;
      else if (bus.wr_enable) mem[bus.wr_addr] <= bus.wr_data;
      rd_q <= mem[bus.rd_addr];
   end
   assign bus.rd_data = rd_q;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Activity log sampled on the falling edge.
   int          wr_cyc_q[$];
   logic [15:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
   int          busy_cnt = 0;
   int          done_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.wr_enable) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(bus.wr_addr);
            wr_data_q.push_back(bus.wr_data);
         end
         if (bus.busy) begin
            busy_cnt = busy_cnt + 1;
            rd_addr_q.push_back(bus.rd_addr);
         end
         if (bus.done) done_cnt = done_cnt + 1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   int start_cyc, w_base, b_base, r_base, d_base;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [15:0] a, input logic [15:0] d);
      tb_we    = 1'b1;
      tb_waddr = a;
      tb_wdata = d;
      tick();
      tb_we    = 1'b0;
   endtask

   task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
      w_base    = wr_addr_q.size();
      b_base    = busy_cnt;
      r_base    = rd_addr_q.size();
      d_base    = done_cnt;
      bus.start = 1'b1;
      bus.src   = s;
      bus.dst   = d;
      bus.len   = l;
      start_cyc = cyc;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int i;
      i = 0;
      while (!bus.done && i < max_cyc) begin
         tick();
         i++;
      end
      check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
   endtask

   task automatic check_xfer(input string tag, input int lat, input int nwr, input int nbusy);
      check({tag, "_latency"}, 32'(cyc - start_cyc), 32'(lat));
      check({tag, "_writes"}, 32'(wr_addr_q.size() - w_base), 32'(nwr));
      check({tag, "_busy_cycles"}, 32'(busy_cnt - b_base), 32'(nbusy));
   endtask

   task automatic check_wr(input string tag, input int i, input logic [15:0] a,
                           input logic [15:0] d);
      int idx;
      idx = w_base + i;
      if (idx < wr_addr_q.size()) begin
         check($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr_q[idx]), 32'(a));
         check($sformatf("%s_wr%0d_data", tag, i), 32'(wr_data_q[idx]), 32'(d));
         check($sformatf("%s_wr%0d_cycle", tag, i), 32'(wr_cyc_q[idx]), 32'(start_cyc + 2 + i));
      end else begin
         check($sformatf("%s_wr%0d_present", tag, i), 32'(wr_addr_q.size()), 32'(idx + 1));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_wr_enable"}, 32'(bus.wr_enable), 32'd0);
      check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
      check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
      check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] exp_d [4];
      logic [15:0] wrap_d [4];
      logic [15:0] wrap_r [4];
      exp_d  = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
      wrap_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      wrap_r = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.src   = '0;
      bus.dst   = '0;
      bus.len   = '0;
`ifdef MEM_COPY_FILL_EN
      bus.fill       = 1'b0;
      bus.fill_value = '0;
`endif
      tb_we    = 1'b0;
      tb_waddr = '0;
      tb_wdata = '0;
      #1;
      check_idle_outputs("reset");

      for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), exp_d[i]);
      for (int i = 0; i < 4; i++) poke(wrap_r[i], wrap_d[i]);
      poke(16'h0005, 16'h1234);
      poke(16'h0020, 16'hBEEF);
      poke(16'h0503, 16'hDEAD);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic copy of four words
      launch(16'h0010, 16'h0100, 16'd4);
      wait_done("basic", 20);
      check_xfer("basic", 6, 4, 5);
      for (int i = 0; i < 4; i++) begin
         check_wr("basic", i, 16'h0100 + 16'(i), exp_d[i]);
         check($sformatf("basic_mem%0d", i), 32'(mem[16'h0100 + 16'(i)]), 32'(exp_d[i]));
      end
      tick();

      // Zero length: straight to done, no writes
      launch(16'h0000, 16'h0020, 16'd0);
      wait_done("len0", 10);
      check_xfer("len0", 1, 0, 0);
      check("len0_mem", 32'(mem[16'h0020]), 32'h0000BEEF);
      tick();

      // Single word
      launch(16'h0005, 16'h0009, 16'd1);
      wait_done("len1", 10);
      check_xfer("len1", 3, 1, 2);
      check_wr("len1", 0, 16'h0009, 16'h1234);
      tick();

      // Source address wrap
      launch(16'hFFFE, 16'h7FFF, 16'd4);
      wait_done("wrap", 20);
      check_xfer("wrap", 6, 4, 5);
      for (int i = 0; i < 4; i++) begin
         check_wr("wrap", i, 16'h7FFF + 16'(i), wrap_d[i]);
         check($sformatf("wrap_rd%0d", i), 32'(rd_addr_q[r_base + i]), 32'(wrap_r[i]));
      end
      tick();

      // Start while busy is ignored; start during FIN is accepted
      launch(16'h0010, 16'h0200, 16'd2);
      bus.start = 1'b1;
      bus.src   = 16'h0040;
      bus.dst   = 16'h0400;
      bus.len   = 16'd0;
      tick();
      bus.start = 1'b0;
      wait_done("b2b_a", 10);
      check_xfer("b2b_a", 4, 2, 3);
      check_wr("b2b_a", 0, 16'h0200, 16'h00A1);
      check_wr("b2b_a", 1, 16'h0201, 16'h00B2);
      launch(16'h0005, 16'h0300, 16'd1);
      check("b2b_b_prime_busy", 32'(bus.busy), 32'd1);
      check("b2b_b_prime_rd_addr", 32'(bus.rd_addr), 32'h00000005);
      wait_done("b2b_b", 10);
      check_xfer("b2b_b", 3, 1, 2);
      check("b2b_b_mem", 32'(mem[16'h0300]), 32'h00001234);
      tick();

      // Reset mid-stream after three committed writes
      launch(16'h0010, 16'h0500, 16'd8);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      check("midrst_writes", 32'(wr_addr_q.size() - w_base), 32'd3);
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) tick();
      check("midrst_no_more_writes", 32'(wr_addr_q.size() - w_base), 32'd3);
      check("midrst_no_done", 32'(done_cnt - d_base), 32'd0);
      for (int i = 0; i < 3; i++)
         check($sformatf("midrst_mem%0d", i), 32'(mem[16'h0500 + 16'(i)]), 32'(exp_d[i]));
      check("midrst_mem3_untouched", 32'(mem[16'h0503]), 32'h0000DEAD);

`ifdef MEM_COPY_FILL_EN
      // Fill three words with a constant
      bus.fill       = 1'b1;
      bus.fill_value = 16'h55AA;
      launch(16'h0010, 16'h0600, 16'd3);
      bus.fill       = 1'b0;
      wait_done("fill", 20);
      check_xfer("fill", 5, 3, 4);
      for (int i = 0; i < 3; i++) check_wr("fill", i, 16'h0600 + 16'(i), 16'h55AA);
      check("fill_src_intact", 32'(mem[16'h0010]), 32'h000000A1);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator on the standard memory port (16-bit rd_addr/wr_addr, wr_enable, wr_data, rd_data; read always enabled; 1-cycle read latency; no ready).
- Copies a block of len words from src to dst in the same memory, streaming 1 word/cycle after a 1-cycle prime.
- Used by the CPU/audio path for buffer moves; sits between a control register block (start/done) and any memory module.

Parameters:
- width, 16, data word width; matches the attached memory's width.
- LEN_W, 16, width of the len field.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- start  input  1  request; accepted only when busy=0
- src  input  16  source base address, sampled on accept
- dst  input  16  destination base address, sampled on accept
- len  input  LEN_W  word count, sampled on accept
- busy  output  1  transfer in progress
- done  output  1  one-cycle completion pulse
- rd_addr  output  16  memory read address
- wr_addr  output  16  memory write address
- wr_enable  output  1  memory write strobe
- wr_data  output  width  memory write data
- rd_data  input  width  memory read data; valid the cycle after rd_addr is presented

Behaviour:
- Interface: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset: state IDLE; busy=0, done=0, wr_enable=0; rd_addr, wr_addr, wr_data = 0; counters = 0. Reset mid-transfer aborts immediately. Writes already committed stay; no done pulse.
- States: IDLE, PRIME, STREAM, DRAIN, FIN.
- IDLE:
  - start=1 latches src, dst, len.
  - len=0 -> FIN.
  - Otherwise -> PRIME.
  - start while busy=1 is ignored.
- PRIME (1 cycle): rd_addr=src, wr_enable=0, busy=1, k=1.
  - len=1 -> DRAIN.
  - Otherwise -> STREAM.
- STREAM:
  - Each cycle: rd_addr=src+k, wr_addr=dst+k-1, wr_data=rd_data, wr_enable=1; then k++.
  - When k=len-1 has been issued -> DRAIN.
- DRAIN (1 cycle): wr_addr=dst+len-1, wr_data=rd_data, wr_enable=1, no new read. Then -> FIN.
- FIN (1 cycle): done=1, busy=0, wr_enable=0 -> IDLE.
  - A start in the FIN cycle is accepted; the next transfer starts at PRIME the following cycle.
- busy timing: busy=1 in PRIME, STREAM and DRAIN. Total cycles from accept to done = len+2 (len>0), or 1 (len=0).
- Output decode: rd_addr, wr_addr, wr_enable and wr_data are combinational from the state and registered counters. wr_data passes rd_data straight through; this meets the 1-cycle latency with no extra storage.
- Arithmetic: address additions are modulo 2^16, so addresses wrap 0xFFFF -> 0x0000 without error.
- Overlap:
  - dst<=src, or no overlap: copy is exact.
  - dst in (src, src+len): unsupported; result undefined, and the bench does not check it.
- rd_addr when not streaming: holds the last value. The memory is read-always, so this has no side effect.

Optional Feature:
- Macro: MEM_COPY_FILL_EN.
- Defined:
  - Adds inputs fill (1) and fill_value (width), both sampled on accept.
  - fill=1: same state sequence and timing, but wr_data=fill_value and rd_addr is not advanced.
  - fill=0: normal copy.
- Undefined: ports absent; copy only.

Decomposition:
- Package mem_copy_pkg: state enum (IDLE, PRIME, STREAM, DRAIN, FIN) and ADDR_W=16 constant.
- No sub-module; the FSM plus a k counter fit in a single module.

Test Plan:
- Basic copy: mem[0x0010..0x0013]={A1,B2,C3,D4}; start src=0x0010, dst=0x0100, len=4 -> writes to 0x0100..0x0103 on consecutive cycles with matching data; done pulse 6 cycles after accept; busy high exactly 5 cycles.
- len=0: start src=0, dst=0x20 -> no wr_enable; done 1 cycle after accept.
- len=1: src=0x5, dst=0x9 -> one write, 0x9=mem[0x5]; done 3 cycles after accept.
- Wrap: src=0xFFFE, dst=0x7FFF, len=4 -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001; writes 0x7FFF..0x8002.
- Back-to-back and ignored start: start pulsed while busy is ignored; start in the FIN cycle is accepted, with PRIME the next cycle.
- Reset mid-stream: len=8, assert rst_n=0 after 3 writes -> outputs zero immediately, no done, no further writes. With MEM_COPY_FILL_EN: fill=1, fill_value=0x55AA, len=3 -> three writes of 0x55AA.
